// File: rtl/sum_pkg.sv
// Shared definitions for the summator and its BCD conversion stage.
// Provides the converter state enum, bus-width constants and a digit-count helper.
package sum_pkg;

    localparam int SUM_WIDTH  = 8;
    localparam int BCD_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Decimal digits needed to show the largest unsigned value of a width.
    function automatic int bcd_digits_for(input int width);
        longint max_val;
        int     n;
        max_val = (longint'(1) << width) - 64'd1;
        n = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more.
// Ports: nibble (4-bit digit in), adjusted (4-bit corrected digit out).
module bcd_nibble_adjust (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-packed-BCD converter behind the summator, one bit per clock.
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready upstream handshake;
// out_bcd/out_bin/out_valid/out_ready downstream handshake, result held until consumed.
module sum_bcd_converter
    import sum_pkg::*;
#(
    parameter int WIDTH  = SUM_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [WIDTH-1:0]      out_bin,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    if (DIGITS < bcd_digits_for(WIDTH)) begin : g_digits_check
        $error("DIGITS too small for WIDTH");
    end

    conv_state_t state;
    conv_state_t state_next;

    logic [WIDTH-1:0]    bin_shift;
    logic [BW-1:0]       bcd_acc;
    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [CW-1:0]       cnt;
    logic                last_shift;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nibble   (bcd_acc[4*d +: 4]),
            .adjusted (bcd_adj[4*d +: 4])
        );
    end

    // Top bit of the adjusted accumulator is always 0 and falls off here.
    assign shifted    = {bcd_adj, bin_shift} << 1;
    assign last_shift = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_shift <= '0;
            bcd_acc   <= '0;
            out_bin   <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_shift <= in_data;
                        bcd_acc   <= '0;
                        out_bin   <= in_data;
                        cnt       <= '0;
                    end
                end
                SHIFT: begin
                    bcd_acc   <= shifted[BW+WIDTH-1:WIDTH];
                    bin_shift <= shifted[WIDTH-1:0];
                    cnt       <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_bcd = bcd_acc;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: directed steps plus a full
// 0..255 sweep and random values, compared with a decimal-digit model.
module tb_sum_bcd_converter;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_bcd;
    logic [7:0]  out_bin;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;
    int cyc;

    sum_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_bin   (out_bin),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] bcd_ref(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion; result held for 'hold' cycles before out_ready.
    task automatic convert(input logic [7:0] val, input int hold);
        int n;
        int lat;
        logic [11:0] exp_bcd;
        exp_bcd = bcd_ref(int'(val));
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, n < 50}, 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = val;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            in_data = 8'($urandom);
            lat++;
        end
        check("latency", lat, 8);
        check("bcd", {20'd0, out_bcd}, {20'd0, exp_bcd});
        check("bin", {24'd0, out_bin}, {24'd0, val});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_bcd", {20'd0, out_bcd}, {20'd0, exp_bcd});
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", {31'd0, in_ready}, 32'd1);
        check("release_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int acc_cyc[3];
        int n;
        logic [7:0] v;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_bcd", {20'd0, out_bcd}, 32'd0);
        check("rst_out_bin", {24'd0, out_bin}, 32'd0);

        // Directed values and boundaries.
        convert(8'd0, 0);
        convert(8'd99, 0);
        convert(8'd255, 0);

        // Backpressure.
        convert(8'd128, 5);

        // in_valid held high with driver holding data until in_ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(10 + k);
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("stream_wait", {31'd0, n < 50}, 32'd1);
            acc_cyc[k] = cyc;
            @(negedge clk);
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("stream_lat", n, 8);
            check("stream_bcd", {20'd0, out_bcd}, {20'd0, bcd_ref(10 + k)});
            if (k > 0) begin
                check("stream_period", acc_cyc[k] - acc_cyc[k-1], 10);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset during the 4th shift cycle of a conversion of 200.
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wait", {31'd0, n < 50}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_bcd", {20'd0, out_bcd}, 32'd0);
        convert(8'd7, 0);

        // Exhaustive sweep with random backpressure.
        for (int i = 0; i < 256; i++) begin
            convert(8'(i), int'($urandom_range(0, 2)));
        end

        // Random values.
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom_range(0, 255));
            convert(v, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
Downstream stage of the 8-bit summator. It accepts one binary sum per valid/ready handshake and converts it to packed BCD with a sequential double-dabble engine, one bit per clock. It presents the decimal digits for the display/readout logic that follows, and holds them until they are consumed.

Parameters:
WIDTH, 8, binary input width (matches summator sum bus)
DIGITS, 3, number of BCD output digits; 10**DIGITS must exceed 2**WIDTH-1, enforced by elaboration-time assertion

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  binary value to convert (summator sum)
in_valid  input  1  in_data valid
in_ready  output  1  converter can accept a value
out_bcd  output  4*DIGITS  packed BCD result, digit 0 = LSB nibble
out_bin  output  WIDTH  copy of the binary value that produced out_bcd
out_valid  output  1  out_bcd/out_bin valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (synchronous, active-high, sampled at rising clk): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_bin=0, bit counter=0. Reset wins over every other event, including mid-conversion and during DONE; any partial result is discarded.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1:
    - load bin_shift=in_data, bcd_acc=0, out_bin=in_data, cnt=0;
    - go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge:
    - every nibble of bcd_acc >=5 gets +3 (combinational adjust);
    - then {bcd_acc, bin_shift} shifts left by 1;
    - cnt++.
    - On the edge where cnt==WIDTH-1 (the WIDTH-th shift), go to DONE.
  - DONE: out_valid=1, out_bcd=bcd_acc, in_ready=0. On an edge with out_ready=1, go to IDLE. out_bcd/out_bin stay stable while out_valid=1 && out_ready=0.
- Latency: acceptance at edge T gives out_valid=1 in the cycle after edge T+WIDTH (8 cycles for WIDTH=8).
- Throughput: with out_ready tied high, minimum period is WIDTH+2 cycles per conversion (10 for default).
- in_data is sampled only at acceptance. Changes to in_data during SHIFT/DONE have no effect.
- in_valid while not IDLE is ignored: no acceptance, no error. The upstream must hold the value until in_ready.
- out_ready while not DONE is ignored.
- Arithmetic:
  - adjust is 4-bit unsigned add per nibble; no carry between nibbles;
  - shift carries the MSB of each nibble into the next;
  - the MSB shifted out of the top nibble is always 0 given the parameter constraint.
- Boundaries:
  - in_data=0 gives out_bcd=0;
  - in_data=2**WIDTH-1 gives the maximum decimal value with no overflow.
- Counter width: $clog2(WIDTH); wrap-around is never reached because the state leaves SHIFT at WIDTH-1.

Decomposition:
- Shared package sum_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - SUM_WIDTH=8 constant shared with the summator;
  - BCD_DIGITS=3 constant;
  - function returning the required digit count for a width, used by the assertion.
- One natural sub-module: bcd_nibble_adjust. It is combinational, 4-bit in, 4-bit out, +3 if >=5, and is instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in sum_bcd_converter.

Test Plan:
- Reset held 3 cycles, then released -> in_ready=1, out_valid=0, out_bcd=12'h000 on the first post-reset cycle.
- Send in_data=8'd0, then 8'd99, then 8'd255, with out_ready=1 -> out_bcd=12'h000, 12'h099, 12'h255 respectively. out_valid rises exactly 8 cycles after each acceptance edge; out_bin echoes each input.
- Send in_data=8'd128 with out_ready=0 for 5 cycles after out_valid -> out_bcd holds 12'h128 and in_ready stays 0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Keep in_valid high continuously with incrementing data 8'd10, 8'd11, 8'd12 -> only one acceptance per 10-cycle period. Outputs are 12'h010, 12'h011, 12'h012; the driver holds each value until in_ready.
- Accept in_data=8'd200, assert reset during the 4th SHIFT cycle -> next cycle state IDLE, out_valid=0, out_bcd=0. A new value 8'd7 then converts to 12'h007.
- Exhaustive sweep of 0..255 against a reference model -> every out_bcd matches the decimal digits and every latency equals 8.
